branch_predict_unit: RTL and testbench

Parametrised EX-stage branch resolver with a direct-mapped branch target buffer (BTB) and 2-bit direction predictor. Fetch looks up a predicted next PC each cycle. EX resolves branch, JAL, JALR and HALT, and redirects fetch only on a misprediction. A sticky HALT state holds fetch at the halting PC until reset. It replaces the always-redirect-on-taken resolver and sits between the IF and EX pipeline stages.

---
 rtl/branch_pkg.sv | 41 ++++
 rtl/bp_btb.sv | 44 ++++
 rtl/branch_predict_unit.sv | 182 ++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// ============================================================================
// Module      : branch_pkg
// Description : Shared types, counter encodings and saturating helpers for
//               the BTB-based branch predict unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pkg;

    // Tag field sized for the widest legal PC; unused upper bits stay zero.
    localparam int TAG_MAX_W = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } bp_state_e;

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == CTR_ST) ? CTR_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_btb.sv
// ============================================================================
// Module      : bp_btb
// Description : Direct-mapped branch target buffer with two combinational
//               read ports (fetch, EX) and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_btb
    import branch_pkg::*;
#(
    parameter int BTB_DEPTH = 16,
    parameter int IDX_W     = $clog2(BTB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_a_idx_i,
    output btb_entry_t       rd_a_entry_o,
    input  logic [IDX_W-1:0] rd_b_idx_i,
    output btb_entry_t       rd_b_entry_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  btb_entry_t       wr_entry_i
);

    btb_entry_t mem_q [BTB_DEPTH];

    // Reads see the pre-write contents; there is deliberately no bypass.
    assign rd_a_entry_o = mem_q[rd_a_idx_i];
    assign rd_b_entry_o = mem_q[rd_b_idx_i];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module      : branch_predict_unit
// Description : EX-stage branch resolver with BTB + 2-bit direction predictor;
//               redirects only on mispredict, sticky HALT until reset.
//               Optional statistics counters: define BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    output logic [31:0]     if_pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [31:0]     ex_imm,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic            ex_halt,
    input  logic [31:0]     ex_alu_result,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic [31:0]     pc_imm,
    output logic [31:0]     pc_four,
    output logic [31:0]     br_pc,
    output logic            pc_sel,
    output logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(BTB_DEPTH);

    bp_state_e         state_q;
    logic [PC_W-1:0]   halt_pc_q;

    logic [IDX_W-1:0]     if_idx;
    logic [IDX_W-1:0]     ex_idx;
    logic [TAG_MAX_W-1:0] if_tag;
    logic [TAG_MAX_W-1:0] ex_tag;
    btb_entry_t           if_entry;
    btb_entry_t           ex_entry;
    btb_entry_t           wr_entry;
    logic                 wr_en;
    logic                 if_hit;
    logic                 ex_hit;
    logic                 ex_active;
    logic                 actual_taken;
    logic                 mispredict;
    logic [31:0]          pc_ext;
    logic                 unused_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign if_tag = TAG_MAX_W'(if_pc[PC_W-1:IDX_W+2]);
    assign ex_tag = TAG_MAX_W'(ex_pc[PC_W-1:IDX_W+2]);

    bp_btb #(
        .BTB_DEPTH (BTB_DEPTH),
        .IDX_W     (IDX_W)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_a_idx_i   (if_idx),
        .rd_a_entry_o (if_entry),
        .rd_b_idx_i   (ex_idx),
        .rd_b_entry_o (ex_entry),
        .wr_en_i      (wr_en),
        .wr_idx_i     (ex_idx),
        .wr_entry_i   (wr_entry)
    );

    // Fetch-side lookup
    assign if_hit         = if_entry.valid && (if_entry.tag == if_tag);
    assign if_pred_taken  = rst_n && if_hit && if_entry.ctr[1];
    assign if_pred_target = if_pred_taken ? if_entry.target : 32'd0;
    assign unused_bits    = ^{if_pc[1:0], if_entry.ctr[0]};

    // EX-side resolution
    assign pc_ext       = 32'(ex_pc);
    assign pc_four      = pc_ext + 32'd4;
    assign pc_imm       = ex_jalr ? ex_alu_result : pc_ext + ex_imm;
    assign ex_active    = ex_valid && (state_q == RUN);
    assign ex_hit       = ex_entry.valid && (ex_entry.tag == ex_tag);
    assign actual_taken = (ex_branch && ex_alu_result[0]) || ex_jal || ex_jalr;
    assign mispredict   = ex_active &&
                          ((actual_taken != ex_pred_taken) ||
                           (actual_taken && (ex_pred_target != pc_imm)));

    assign flush  = rst_n && mispredict;
    assign pc_sel = rst_n && ((state_q == HALT) ||
                              (ex_active && (ex_halt || mispredict)));

    // A resolving HALT outranks any mispredict redirect in the same cycle.
    always_comb begin
        br_pc = 32'd0;
        if (rst_n) begin
            if (state_q == HALT) begin
                br_pc = 32'(halt_pc_q);
            end else if (ex_active && ex_halt) begin
                br_pc = pc_ext;
            end else if (mispredict) begin
                br_pc = actual_taken ? pc_imm : pc_four;
            end
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (ex_active && ex_branch) begin
            if (ex_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ex_alu_result[0] ? ctr_sat_inc(ex_entry.ctr)
                                                : ctr_sat_dec(ex_entry.ctr);
                if (ex_alu_result[0]) begin
                    wr_entry.target = pc_imm;
                end
            end else if (ex_alu_result[0]) begin
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: ex_tag, target: pc_imm, ctr: CTR_WT};
            end
        end else if (ex_active && ex_jal) begin
            wr_en    = 1'b1;
            wr_entry = '{valid: 1'b1, tag: ex_tag, target: pc_imm, ctr: CTR_ST};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            halt_pc_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_valid && ex_halt) begin
                        state_q   <= HALT;
                        halt_pc_q <= ex_pc;
                    end
                end
                HALT:    state_q <= HALT;
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            if (ex_active && (ex_branch || ex_jal || ex_jalr) && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict && (stat_mp_q != '1)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Directed self-checking bench for branch_predict_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_BR   = 4'b1000;
    localparam logic [3:0] C_JAL  = 4'b0100;
    localparam logic [3:0] C_JALR = 4'b0010;
    localparam logic [3:0] C_HALT = 4'b0001;

`ifdef BRANCH_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    // Hit-sequence table for the branch at 0x20 (entry i = bit i).
    localparam logic [5:0] T_TAKEN = 6'b100011;
    localparam logic [5:0] T_PRED  = 6'b001111;
    localparam logic [5:0] T_MP    = 6'b101100;
    localparam logic [5:0] T_AFTER = 6'b000111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic [8:0]  ex_pc;
    logic [31:0] ex_imm;
    logic        ex_branch, ex_jal, ex_jalr, ex_halt;
    logic [31:0] ex_alu_result;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] pc_imm, pc_four, br_pc;
    logic        pc_sel, flush;
    logic [31:0] stat_branches, stat_mispredicts;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(9), .BTB_DEPTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_branch        (ex_branch),
        .ex_jal           (ex_jal),
        .ex_jalr          (ex_jalr),
        .ex_halt          (ex_halt),
        .ex_alu_result    (ex_alu_result),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .pc_imm           (pc_imm),
        .pc_four          (pc_four),
        .br_pc            (br_pc),
        .pc_sel           (pc_sel),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [8:0] pc, input logic [31:0] imm,
                          input logic [3:0] cls, input logic [31:0] alu,
                          input logic pt, input logic [31:0] ptg);
        ex_valid       = v;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_branch      = cls[3];
        ex_jal         = cls[2];
        ex_jalr        = cls[1];
        ex_halt        = cls[0];
        ex_alu_result  = alu;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
        #1;
    endtask

    task automatic lookup(input string tag, input logic [8:0] pc,
                          input logic exp_t, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, 32'(if_pred_taken), 32'(exp_t));
        check({tag, "_target"}, if_pred_target, exp_tgt);
    endtask

    task automatic check_stats(input string tag, input int br, input int mp);
        check({tag, "_stat_br"}, stat_branches, 32'(br * STATS_ON));
        check({tag, "_stat_mp"}, stat_mispredicts, 32'(mp * STATS_ON));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_br;

        rst_n = 1'b0;
        if_pc = 9'h020;
        ex_set(1'b1, 9'h020, 32'h40, C_BR, 32'd1, 1'b0, 32'd0);
        check("rst_pc_sel", 32'(pc_sel), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_br_pc", br_pc, 32'd0);
        check("rst_pc_imm", pc_imm, 32'h60);
        check("rst_pc_four", pc_four, 32'h24);
        tick();
        tick();

        rst_n = 1'b1;
        ex_set(1'b0, 9'h0, 32'h0, C_NONE, 32'h0, 1'b0, 32'h0);
        lookup("post_rst", 9'h010, 1'b0, 32'd0);
        check("post_rst_pc_sel", 32'(pc_sel), 32'd0);
        check_stats("post_rst", 0, 0);

        // Allocate on taken miss; same-cycle lookup still sees the miss.
        ex_set(1'b1, 9'h020, 32'h40, C_BR, 32'd1, 1'b0, 32'd0);
        lookup("alloc_same", 9'h020, 1'b0, 32'd0);
        check("alloc_pc_sel", 32'(pc_sel), 32'd1);
        check("alloc_flush", 32'(flush), 32'd1);
        check("alloc_br_pc", br_pc, 32'h60);
        tick();
        ex_set(1'b0, 9'h0, 32'h0, C_NONE, 32'h0, 1'b0, 32'h0);
        lookup("alloc_next", 9'h020, 1'b1, 32'h60);
        lookup("tag_alias", 9'h060, 1'b0, 32'd0);
        check("idle_pc_sel", 32'(pc_sel), 32'd0);

        // Counter walk: 10 -> 11 -> 11 -> 10 -> 01 -> 00 -> 01
        for (int i = 0; i < 6; i++) begin
            ex_set(1'b1, 9'h020, 32'h40, C_BR, 32'(T_TAKEN[i]), T_PRED[i],
                   T_PRED[i] ? 32'h60 : 32'h0);
            exp_br = T_MP[i] ? (T_TAKEN[i] ? 32'h60 : 32'h24) : 32'd0;
            check($sformatf("walk%0d_flush", i), 32'(flush), 32'(T_MP[i]));
            check($sformatf("walk%0d_pc_sel", i), 32'(pc_sel), 32'(T_MP[i]));
            check($sformatf("walk%0d_br_pc", i), br_pc, exp_br);
            tick();
            ex_set(1'b0, 9'h0, 32'h0, C_NONE, 32'h0, 1'b0, 32'h0);
            lookup($sformatf("walk%0d_after", i), 9'h020, T_AFTER[i],
                   T_AFTER[i] ? 32'h60 : 32'h0);
            if (i == 2) check_stats("walk2", 4, 2);
        end
        check_stats("walk_end", 7, 4);

        // ex_valid low: no redirect, no update (ctr stays 01)
        ex_set(1'b0, 9'h020, 32'h40, C_BR, 32'd1, 1'b0, 32'h0);
        check("novalid_pc_sel", 32'(pc_sel), 32'd0);
        check("novalid_flush", 32'(flush), 32'd0);
        tick();
        lookup("novalid_after", 9'h020, 1'b0, 32'd0);

        ex_set(1'b1, 9'h050, 32'h10, C_JAL, 32'h0, 1'b0, 32'h0);
        check("jal_pc_sel", 32'(pc_sel), 32'd1);
        check("jal_br_pc", br_pc, 32'h60);
        tick();
        ex_set(1'b0, 9'h0, 32'h0, C_NONE, 32'h0, 1'b0, 32'h0);
        lookup("jal_after", 9'h050, 1'b1, 32'h60);

        ex_set(1'b1, 9'h030, 32'h0, C_JALR, 32'h100, 1'b1, 32'hFC);
        check("jalr_pc_imm", pc_imm, 32'h100);
        check("jalr_flush", 32'(flush), 32'd1);
        check("jalr_br_pc", br_pc, 32'h100);
        tick();
        ex_set(1'b0, 9'h0, 32'h0, C_NONE, 32'h0, 1'b0, 32'h0);
        lookup("jalr_after", 9'h030, 1'b0, 32'd0);
        check_stats("pre_halt", 9, 6);

        ex_set(1'b1, 9'h044, 32'h0, C_HALT, 32'h0, 1'b0, 32'h0);
        check("halt_res_pc_sel", 32'(pc_sel), 32'd1);
        check("halt_res_br_pc", br_pc, 32'h44);
        check("halt_res_flush", 32'(flush), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            ex_set(1'b1, 9'h020, 32'h40, C_BR, 32'd1, 1'b0, 32'h0);
            check($sformatf("halt%0d_pc_sel", i), 32'(pc_sel), 32'd1);
            check($sformatf("halt%0d_br_pc", i), br_pc, 32'h44);
            check($sformatf("halt%0d_flush", i), 32'(flush), 32'd0);
            tick();
        end
        ex_set(1'b0, 9'h0, 32'h0, C_NONE, 32'h0, 1'b0, 32'h0);
        lookup("halt_btb", 9'h020, 1'b0, 32'd0);
        check("halt_idle_br_pc", br_pc, 32'h44);
        check_stats("halt", 9, 6);

        rst_n = 1'b0;
        lookup("halt_rst", 9'h050, 1'b0, 32'd0);
        check("halt_rst_pc_sel", 32'(pc_sel), 32'd0);
        check("halt_rst_br_pc", br_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rerun_pc_sel", 32'(pc_sel), 32'd0);
        check("rerun_br_pc", br_pc, 32'd0);
        lookup("rerun_btb", 9'h050, 1'b0, 32'd0);
        check_stats("rerun", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
